// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, PC step,
// fetch state codes and the {pc,instr} queue entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A fetch target is misaligned when it is not on a 32-bit word boundary.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc,instr} pairs. DEPTH must be a power of two so the
// read/write pointers wrap naturally. A clear wins over a same-cycle push/pop;
// a push into a full queue is accepted only when a pop frees a slot that cycle.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Storage, pointers and occupancy; clear empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'h0;
      end
    end else if (clear_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, buffers {pc,instr} in fetch_queue and presents the head to
// decode. Redirects flush all wrong-path state and restart fetch at the new PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined a misaligned
// redirect halts fetch (FAULT) and raises fetch_fault until an aligned redirect;
// when undefined redirect targets are forced to word alignment.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic          inflight_epoch_q;
  logic          epoch_q;

  logic [63:0]   q_head_s;
  logic [CW-1:0] q_count_s;
  logic          q_full_s;
  logic          q_empty_s;
  logic          pop_s;
  logic          push_s;
  logic [SW-1:0] occ_s;
  logic          room_s;
  logic [31:0]   redir_pc_s;
  logic          redir_bad_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc_s  = redirect_pc;
  assign redir_bad_s = pc_misaligned(redirect_pc);
  assign fetch_fault = (state_q == FETCH_FAULT);
`else
  assign redir_pc_s  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad_s = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Head is hidden during a redirect so no wrong-path instruction transfers.
  assign if_valid = !q_empty_s && !redirect_valid && (state_q == FETCH_RUN);
  assign pop_s    = if_valid && if_ready;
  assign head_s   = q_head_s;
  assign if_pc    = q_empty_s ? 32'h0000_0000 : head_s.pc;
  assign if_instr = q_empty_s ? NOP_INSTR : head_s.instr;

  // Occupancy after this cycle's pop plus the read in flight plus a new read.
  assign occ_s  = SW'(q_count_s) - SW'(pop_s) + SW'(inflight_q) + SW'(1);
  assign room_s = (occ_s <= SW'(DEPTH)) && !(q_full_s && !pop_s);

  // rst gates the request so nothing is issued while reset is asserted.
  assign imem_req  = rst && (state_q == FETCH_RUN) && !redirect_valid && room_s;
  assign imem_addr = pc_q[31:2];

  // Responses from a previous epoch belong to a flushed path and are dropped.
  assign push_s       = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid;
  assign push_entry_s = '{pc: inflight_pc_q, instr: imem_rdata};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_valid),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (push_entry_s),
    .head_o  (q_head_s),
    .count_o (q_count_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s)
  );

  // Fetch FSM: PC advance, in-flight tracking, redirect flush and fault entry/exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= FETCH_RUN;
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= 32'h0000_0000;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redir_pc_s;
      epoch_q    <= ~epoch_q;
      inflight_q <= 1'b0;
      if (redir_bad_s) begin
        state_q <= FETCH_FAULT;
      end else begin
        state_q <= FETCH_RUN;
      end
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q             <= pc_q + PC_STEP;
        inflight_pc_q    <= pc_q;
        inflight_epoch_q <= epoch_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory responder answers every read one
// cycle later with a word derived from its address. The reference model is the
// architectural instruction stream: after reset or a redirect to T, decode must
// see T, T+4, T+8 ... (32-bit wrap) with the matching memory words, and fetch
// addresses must follow the same sequence. Expected pairs are queued by the
// driver; a negedge monitor pops and compares on every transfer.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] exp_fetch;
  int          outstanding = 0;
  logic        fault_exp = 1'b0;
  logic        fault_prev = 1'b0;
  logic        held_prev = 1'b0;
  logic [31:0] held_pc, held_instr;
  logic        mon_en = 1'b0;
  logic        last_was_top = 1'b0;
  logic        saw_wrap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic model_fault(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: word address captured mid-cycle, data presented the following cycle.
  initial begin
    logic        cap_req;
    logic [29:0] cap_addr;
    forever begin
      @(negedge clk);
      cap_req  = imem_req;
      cap_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = cap_req ? mem_word(cap_addr) : 32'hDEAD_BEEF;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic topup();
    if (!fault_exp) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
    end
  endtask

  task automatic model_restart(input logic [31:0] t);
    exp_q.delete();
    gen_pc      = model_target(t);
    exp_fetch   = model_target(t);
    outstanding = 0;
    fault_exp   = model_fault(t);
    topup();
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] tgt);
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (redir) model_restart(tgt);
    topup();
  endtask

  task automatic wait_head(input string nm, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!if_valid && n < 20) begin
      step();
      drive(1'b1, 1'b0, 32'h0);
      sample();
      n++;
    end
    if (!if_valid) chk({nm, "_timeout"}, {31'h0, if_valid}, 32'h1);
    else chk(nm, if_pc, exp_pc);
  endtask

  // Monitor: compares every transfer and fetch against the reference stream.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, fault_prev});
      if (redirect_valid) begin
        chk("redir_valid_mask", {31'h0, if_valid}, 32'h0);
        chk("redir_no_req", {31'h0, imem_req}, 32'h0);
      end else begin
        if (fault_prev && (imem_req || if_valid)) begin
          chk("fault_quiet", {30'h0, imem_req, if_valid}, 32'h0);
        end
        if (imem_req) begin
          chk("imem_addr", {2'b00, imem_addr}, {2'b00, exp_fetch[31:2]});
          exp_fetch   = exp_fetch + 32'd4;
          outstanding = outstanding + 1;
        end
        if (held_prev) begin
          chk("hold_valid", {31'h0, if_valid}, 32'h1);
          chk("hold_pc", if_pc, held_pc);
          chk("hold_instr", if_instr, held_instr);
        end
        if (if_valid && if_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer_pc", if_pc, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("xfer_pc", if_pc, e);
            chk("xfer_instr", if_instr, mem_word(e[31:2]));
            if (last_was_top && e == 32'h0) saw_wrap = 1'b1;
            last_was_top = (e == 32'hFFFF_FFFC);
          end
          outstanding = outstanding - 1;
        end
        if (outstanding > DEPTH) chk("occupancy", outstanding, DEPTH);
      end
      held_prev  = if_valid && !if_ready && !redirect_valid;
      held_pc    = if_pc;
      held_instr = if_instr;
      fault_prev = fault_exp;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    sample();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // 1: streaming from RESET_PC with decode always ready.
    step();
    rst = 1'b1;
    model_restart(RESET_PC);
    fault_prev = 1'b0;
    held_prev  = 1'b0;
    mon_en     = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("t1_req", {31'h0, imem_req}, 32'h1);
      chk("t1_addr", {2'b00, imem_addr}, k);
      if (k >= 2) begin
        chk("t1_valid", {31'h0, if_valid}, 32'h1);
        chk("t1_pc", if_pc, 32'(4 * (k - 2)));
      end else begin
        chk("t1_not_valid", {31'h0, if_valid}, 32'h0);
      end
      step();
      drive(1'b1, 1'b0, 32'h0);
    end

    // 2: decode stalls for 10 cycles -> queue fills to DEPTH and fetch stops.
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      drive(1'b0, 1'b0, 32'h0);
      sample();
    end
    chk("t2_req_stopped", {31'h0, imem_req}, 32'h0);
    chk("t2_held", outstanding, DEPTH);
    chk("t2_valid", {31'h0, if_valid}, 32'h1);

    // 3: redirect from a full queue.
    step();
    drive(1'b0, 1'b1, 32'h0000_0100);
    sample();
    chk("t3_masked", {31'h0, if_valid}, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("t3_req", {31'h0, imem_req}, 32'h1);
    chk("t3_addr", {2'b00, imem_addr}, 32'h40);
    wait_head("t3_first_pc", 32'h0000_0100);

    // 4: redirect in the response cycle of 0x8, then back-to-back redirects.
    step();
    drive(1'b1, 1'b1, 32'h0000_0008);
    sample();
    step();
    drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("t4_addr8", {2'b00, imem_addr}, 32'h2);
    step();
    drive(1'b1, 1'b1, 32'h0000_0200);
    sample();
    step();
    drive(1'b1, 1'b1, 32'h0000_0300);
    sample();
    step();
    drive(1'b1, 1'b0, 32'h0);
    sample();
    wait_head("t4_last_wins", 32'h0000_0300);

    // 5: PC wraps past the top of the address space.
    step();
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 8; k++) begin
      sample();
      step();
      drive(1'b1, 1'b0, 32'h0);
    end
    sample();
    chk("t5_wrap_seen", {31'h0, saw_wrap}, 32'h1);

    // 6: misaligned redirect.
    step();
    drive(1'b1, 1'b1, 32'h0000_0102);
    sample();
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b1, 1'b0, 32'h0);
      sample();
      chk("t6_fault", {31'h0, fetch_fault}, 32'h1);
      chk("t6_no_req", {31'h0, imem_req}, 32'h0);
    end
    step();
    drive(1'b1, 1'b1, 32'h0000_0104);
    sample();
    step();
    drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("t6_fault_clear", {31'h0, fetch_fault}, 32'h0);
    wait_head("t6_resume_pc", 32'h0000_0104);
`else
    step();
    drive(1'b1, 1'b0, 32'h0);
    sample();
    wait_head("t6_aligned_pc", 32'h0000_0100);
`endif

    // Randomized traffic: backpressure and redirects to assorted targets.
    for (int k = 0; k < 1500; k++) begin
      logic        rdy, redir;
      logic [31:0] tgt;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        default: tgt = $urandom & 32'h0000_0FFC;
      endcase
      step();
      drive(rdy, redir, tgt);
      sample();
    end
    step();
    drive(1'b1, 1'b1, 32'h0000_0040);
    sample();
    wait_head("rand_exit_pc", 32'h0000_0040);

    // Reset in mid-operation.
    step();
    drive(1'b1, 1'b0, 32'h0);
    mon_en = 1'b0;
    rst    = 1'b0;
    sample();
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_instr", if_instr, NOP);
    step();
    rst = 1'b1;
    model_restart(RESET_PC);
    fault_prev = 1'b0;
    held_prev  = 1'b0;
    mon_en     = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("mid_rst_first_addr", {2'b00, imem_addr}, 32'h0);
    wait_head("mid_rst_first_pc", RESET_PC);
    for (int k = 0; k < 6; k++) begin
      step();
      drive(1'b1, 1'b0, 32'h0);
      sample();
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
